// File: rtl/c2h_sched_pkg.sv
// Shared types and helpers for the C2H credit scheduler.
package c2h_sched_pkg;

    localparam int unsigned QID_W_DEF  = 11;
    localparam int unsigned CRDT_W_DEF = 16;
    localparam int unsigned PEND_W_DEF = 8;

    typedef struct packed {
        logic [CRDT_W_DEF-1:0] credit;
        logic [PEND_W_DEF-1:0] pending;
    } q_state_t;

    // idx is already qid - qid_base in QID_W unsigned arithmetic.
    function automatic logic in_window(input logic [QID_W_DEF-1:0] idx,
                                       input logic [QID_W_DEF-1:0] num_q,
                                       input int unsigned          max_q);
        return (idx < num_q) && (32'(idx) < max_q);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after the pointer.
module rr_arbiter #(
    parameter int unsigned N  = 16,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_vld,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx
);

    always_comb begin
        o_vld = 1'b0;
        o_gnt = '0;
        o_idx = '0;
        for (int k = 0; k < int'(N); k++) begin
            logic [IW-1:0] j;
            // N is a power of two, so the IW-bit sum wraps naturally.
            j = i_ptr + IW'(k);
            if (!o_vld && i_req[j]) begin
                o_vld    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = j;
            end
        end
    end

endmodule

// File: rtl/c2h_credit_sched.sv
// Per-queue C2H descriptor-credit tracker with a round-robin packet grant.
module c2h_credit_sched
    import c2h_sched_pkg::*;
#(
    parameter int unsigned NUM_Q  = 16,
    parameter int unsigned QID_W  = QID_W_DEF,
    parameter int unsigned CRDT_W = CRDT_W_DEF,
    parameter int unsigned PEND_W = PEND_W_DEF
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    input  logic              enable,
    input  logic [QID_W-1:0]  qid_base,
    input  logic [QID_W-1:0]  num_queue,
    input  logic [CRDT_W-1:0] credit_perpkt,
    input  logic              tm_dsc_sts_vld,
    input  logic [QID_W-1:0]  tm_dsc_sts_qid,
    input  logic [15:0]       tm_dsc_sts_avl,
    input  logic              tm_dsc_sts_qinv,
    input  logic              tm_dsc_sts_dir,
    input  logic              tm_dsc_sts_mm,
    output logic              tm_dsc_sts_rdy,
    input  logic              pkt_req_vld,
    input  logic [QID_W-1:0]  pkt_req_qid,
    output logic              pkt_req_rdy,
    output logic              gnt_vld,
    output logic [QID_W-1:0]  gnt_qid,
    input  logic              gnt_rdy,
    input  logic [QID_W-1:0]  rd_qid,
    output logic [CRDT_W-1:0] rd_credit,
    output logic              err_oor
);

    localparam int unsigned IW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1;

    // q_state_t fixes the counter widths; CRDT_W/PEND_W must keep their defaults.
    q_state_t          r_q   [NUM_Q];
    q_state_t          w_q_d [NUM_Q];
    logic              r_gnt_vld;
    logic [QID_W-1:0]  r_gnt_qid;
    logic              r_err_oor;
    logic              r_sts_rdy;
    logic [IW-1:0]     r_rr_ptr;

    logic [QID_W-1:0]  w_sts_off, w_req_off, w_rd_off;
    logic [IW-1:0]     w_sts_idx, w_req_idx, w_rd_idx;
    logic              w_sts_inwin, w_req_inwin, w_rd_inwin;
    logic              w_sts_apply, w_sts_oor, w_req_acc;
    logic [CRDT_W:0]   w_sts_sum;
    logic [CRDT_W-1:0] w_sts_credit;
    logic [NUM_Q-1:0]  w_elig, w_pick_oh;
    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_any, w_arb_run, w_pick;

    assign w_sts_off   = tm_dsc_sts_qid - qid_base;
    assign w_req_off   = pkt_req_qid - qid_base;
    assign w_rd_off    = rd_qid - qid_base;
    assign w_sts_idx   = w_sts_off[IW-1:0];
    assign w_req_idx   = w_req_off[IW-1:0];
    assign w_rd_idx    = w_rd_off[IW-1:0];
    assign w_sts_inwin = in_window(w_sts_off, num_queue, NUM_Q);
    assign w_req_inwin = in_window(w_req_off, num_queue, NUM_Q);
    assign w_rd_inwin  = in_window(w_rd_off, num_queue, NUM_Q);

    assign w_sts_apply = tm_dsc_sts_vld & r_sts_rdy & tm_dsc_sts_dir & ~tm_dsc_sts_mm
                         & w_sts_inwin;
    assign w_sts_oor   = tm_dsc_sts_vld & r_sts_rdy & ~w_sts_inwin;
    assign w_sts_sum   = {1'b0, r_q[w_sts_idx].credit} + (CRDT_W + 1)'(tm_dsc_sts_avl);
    assign w_sts_credit = w_sts_sum[CRDT_W] ? '1 : w_sts_sum[CRDT_W-1:0];

    assign pkt_req_rdy = ~axi_areset & (~w_req_inwin | (r_q[w_req_idx].pending != '1));
    assign w_req_acc   = pkt_req_vld & pkt_req_rdy;

    always_comb begin
        w_elig = '0;
        for (int i = 0; i < int'(NUM_Q); i++) begin
            w_elig[i] = (r_q[i].pending != '0) && (r_q[i].credit >= credit_perpkt)
                        && (QID_W'(i) < num_queue);
        end
    end

    rr_arbiter #(
        .N  (NUM_Q),
        .IW (IW)
    ) u_rr_arbiter (
        .i_req (w_elig),
        .i_ptr (r_rr_ptr),
        .o_vld (w_pick_any),
        .o_gnt (w_pick_oh),
        .o_idx (w_pick_idx)
    );

    assign w_arb_run = enable & (~r_gnt_vld | gnt_rdy);
    assign w_pick    = w_arb_run & w_pick_any;

    always_comb begin
        for (int i = 0; i < int'(NUM_Q); i++) begin
            logic sts_hit, inv_hit, pick_hit;
            w_q_d[i] = r_q[i];
            sts_hit  = w_sts_apply && (w_sts_idx == IW'(i));
            inv_hit  = sts_hit && tm_dsc_sts_qinv;
            pick_hit = w_pick && w_pick_oh[i];
            if (inv_hit) begin
                w_q_d[i].credit = '0;
            end else begin
                if (sts_hit) w_q_d[i].credit = w_sts_credit;
                // Eligibility guaranteed credit >= perpkt, and an add only raises it.
                if (pick_hit) w_q_d[i].credit = w_q_d[i].credit - credit_perpkt;
            end
            if (w_req_acc && w_req_inwin && (w_req_idx == IW'(i))) begin
                w_q_d[i].pending = w_q_d[i].pending + 1'b1;
            end
            if (pick_hit) w_q_d[i].pending = w_q_d[i].pending - 1'b1;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (axi_areset) begin
            r_q       <= '{default: '0};
            r_gnt_vld <= 1'b0;
            r_gnt_qid <= '0;
            r_err_oor <= 1'b0;
            r_sts_rdy <= 1'b0;
            r_rr_ptr  <= '0;
        end else begin
            r_q       <= w_q_d;
            r_sts_rdy <= 1'b1;
            r_err_oor <= r_err_oor | w_sts_oor | (w_req_acc & ~w_req_inwin);
            if (w_pick) begin
                r_gnt_vld <= 1'b1;
                r_gnt_qid <= qid_base + QID_W'(w_pick_idx);
                r_rr_ptr  <= ((QID_W'(w_pick_idx) + 1'b1) >= num_queue) ? '0
                                                                          : w_pick_idx + 1'b1;
            end else begin
                if (!r_gnt_vld || gnt_rdy) r_gnt_vld <= 1'b0;
                if (QID_W'(r_rr_ptr) >= num_queue) r_rr_ptr <= '0;
            end
        end
    end

    assign tm_dsc_sts_rdy = r_sts_rdy;
    assign gnt_vld        = r_gnt_vld;
    assign gnt_qid        = r_gnt_qid;
    assign err_oor        = r_err_oor;
    assign rd_credit      = w_rd_inwin ? r_q[w_rd_idx].credit : '0;

endmodule

// File: tb/tb_c2h_credit_sched.sv
// Scoreboard bench: expected grant qids are queued as stimulus is driven.
module tb_c2h_credit_sched;

    localparam int QID_W  = 11;
    localparam int CRDT_W = 16;

    logic              axi_aclk = 1'b0;
    logic              axi_areset;
    logic              enable;
    logic [QID_W-1:0]  qid_base, num_queue;
    logic [CRDT_W-1:0] credit_perpkt;
    logic              tm_dsc_sts_vld, tm_dsc_sts_qinv, tm_dsc_sts_dir, tm_dsc_sts_mm;
    logic [QID_W-1:0]  tm_dsc_sts_qid;
    logic [15:0]       tm_dsc_sts_avl;
    logic              tm_dsc_sts_rdy;
    logic              pkt_req_vld, pkt_req_rdy;
    logic [QID_W-1:0]  pkt_req_qid;
    logic              gnt_vld, gnt_rdy;
    logic [QID_W-1:0]  gnt_qid;
    logic [QID_W-1:0]  rd_qid;
    logic [CRDT_W-1:0] rd_credit;
    logic              err_oor;

    int          n_chk = 0;
    int          n_err = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_qid;

    c2h_credit_sched dut (
        .axi_aclk        (axi_aclk),
        .axi_areset      (axi_areset),
        .enable          (enable),
        .qid_base        (qid_base),
        .num_queue       (num_queue),
        .credit_perpkt   (credit_perpkt),
        .tm_dsc_sts_vld  (tm_dsc_sts_vld),
        .tm_dsc_sts_qid  (tm_dsc_sts_qid),
        .tm_dsc_sts_avl  (tm_dsc_sts_avl),
        .tm_dsc_sts_qinv (tm_dsc_sts_qinv),
        .tm_dsc_sts_dir  (tm_dsc_sts_dir),
        .tm_dsc_sts_mm   (tm_dsc_sts_mm),
        .tm_dsc_sts_rdy  (tm_dsc_sts_rdy),
        .pkt_req_vld     (pkt_req_vld),
        .pkt_req_qid     (pkt_req_qid),
        .pkt_req_rdy     (pkt_req_rdy),
        .gnt_vld         (gnt_vld),
        .gnt_qid         (gnt_qid),
        .gnt_rdy         (gnt_rdy),
        .rd_qid          (rd_qid),
        .rd_credit       (rd_credit),
        .err_oor         (err_oor)
    );

    always #5 axi_aclk = ~axi_aclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge axi_aclk);
        #1;
    endtask

    task automatic sts(input int q, input int avl, input bit inv, input bit mm);
        tm_dsc_sts_vld  = 1'b1;
        tm_dsc_sts_qid  = QID_W'(q);
        tm_dsc_sts_avl  = 16'(avl);
        tm_dsc_sts_qinv = inv;
        tm_dsc_sts_mm   = mm;
        tick();
        tm_dsc_sts_vld  = 1'b0;
        tm_dsc_sts_qinv = 1'b0;
        tm_dsc_sts_mm   = 1'b0;
    endtask

    task automatic req(input int q);
        pkt_req_vld = 1'b1;
        pkt_req_qid = QID_W'(q);
        tick();
        pkt_req_vld = 1'b0;
    endtask

    task automatic chk_crd(input string tag, input int q, input int exp);
        rd_qid = QID_W'(q);
        #1;
        chk(tag, 32'(rd_credit), 32'(exp));
    endtask

    // Every accepted grant must match the head of the expected queue.
    always @(negedge axi_aclk) begin
        if (!axi_areset && gnt_vld && gnt_rdy) begin
            if (exp_q.size() == 0) begin
                chk("gnt_unexpected", 32'(gnt_qid), 32'hFFFF_FFFF);
            end else begin
                exp_qid = exp_q.pop_front();
                chk("gnt_qid", 32'(gnt_qid), exp_qid);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        axi_areset = 1'b1; enable = 1'b0; qid_base = '0; num_queue = QID_W'(4);
        credit_perpkt = CRDT_W'(4);
        tm_dsc_sts_vld = 1'b0; tm_dsc_sts_qid = '0; tm_dsc_sts_avl = '0;
        tm_dsc_sts_qinv = 1'b0; tm_dsc_sts_dir = 1'b1; tm_dsc_sts_mm = 1'b0;
        pkt_req_vld = 1'b0; pkt_req_qid = '0; gnt_rdy = 1'b1; rd_qid = '0;

        repeat (3) tick();
        chk("rst_gnt_vld", 32'(gnt_vld), 0);
        chk("rst_gnt_qid", 32'(gnt_qid), 0);
        chk("rst_err_oor", 32'(err_oor), 0);
        chk("rst_sts_rdy", 32'(tm_dsc_sts_rdy), 0);
        chk("rst_req_rdy", 32'(pkt_req_rdy), 0);
        axi_areset = 1'b0;
        tick();
        chk("sts_rdy_up", 32'(tm_dsc_sts_rdy), 1);

        // Credit load, no requests: nothing may be granted.
        enable = 1'b1;
        for (int q = 0; q < 4; q++) sts(q, 1024, 1'b0, 1'b0);
        repeat (5) tick();
        chk("load_no_gnt", 32'(gnt_vld), 0);
        for (int q = 0; q < 4; q++) chk_crd("load_credit", q, 1024);

        // Round robin: 8 requests queued while disabled, then released.
        enable = 1'b0;
        for (int i = 0; i < 8; i++) begin
            req(i % 4);
            exp_q.push_back(32'(i % 4));
        end
        enable = 1'b1;
        repeat (9) tick();
        chk("rr_drained", 32'(exp_q.size()), 0);
        chk("rr_idle", 32'(gnt_vld), 0);
        for (int q = 0; q < 4; q++) chk_crd("rr_credit", q, 1016);

        // Starvation on q2 with credit 3 < perpkt 4.
        sts(2, 0, 1'b1, 1'b0);
        sts(2, 3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) req(2);
        repeat (4) tick();
        chk("starve_no_gnt", 32'(gnt_vld), 0);
        chk_crd("starve_credit", 2, 3);
        exp_q.push_back(32'd2);
        exp_q.push_back(32'd2);
        sts(2, 5, 1'b0, 1'b0);
        repeat (5) tick();
        chk("starve_two_gnts", 32'(exp_q.size()), 0);
        chk_crd("starve_credit0", 2, 0);
        // Three requests must remain pending on q2.
        for (int i = 0; i < 3; i++) exp_q.push_back(32'd2);
        sts(2, 12, 1'b0, 1'b0);
        repeat (7) tick();
        chk("starve_pend3", 32'(exp_q.size()), 0);
        chk_crd("starve_credit_end", 2, 0);

        // Backpressure: one grant held, one debit only.
        gnt_rdy = 1'b0;
        req(0);
        req(1);
        for (int i = 0; i < 10; i++) begin
            chk("bp_vld", 32'(gnt_vld), 1);
            chk("bp_qid", 32'(gnt_qid), 0);
            tick();
        end
        chk_crd("bp_credit_q0", 0, 1012);
        chk_crd("bp_credit_q1", 1, 1016);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
        gnt_rdy = 1'b1;
        tick();
        chk("bp_next_vld", 32'(gnt_vld), 1);
        chk("bp_next_qid", 32'(gnt_qid), 1);
        repeat (2) tick();
        chk("bp_drained", 32'(exp_q.size()), 0);
        chk_crd("bp_credit_q1b", 1, 1012);

        // Invalidate lands on the same edge as the q1 grant.
        req(1);
        exp_q.push_back(32'd1);
        sts(1, 0, 1'b1, 1'b0);
        chk_crd("inv_credit", 1, 0);
        repeat (2) tick();
        chk("inv_drained", 32'(exp_q.size()), 0);

        // Out-of-window status and request; memory-mapped status ignored.
        chk("oor_pre", 32'(err_oor), 0);
        sts(7, 100, 1'b0, 1'b0);
        chk("oor_set", 32'(err_oor), 1);
        chk_crd("oor_rd7", 7, 0);
        chk_crd("oor_q3", 3, 1016);
        pkt_req_qid = QID_W'(9);
        #1;
        chk("oor_req_rdy", 32'(pkt_req_rdy), 1);
        sts(3, 50, 1'b0, 1'b1);
        chk_crd("mm_ignored", 3, 1016);
        repeat (3) tick();
        chk("oor_sticky", 32'(err_oor), 1);

        // Saturation.
        sts(0, 16'hFFFF, 1'b0, 1'b0);
        sts(0, 16'hFFFF, 1'b0, 1'b0);
        chk_crd("sat_credit", 0, 16'hFFFF);

        // Reset with an outstanding grant and a leftover pending request.
        gnt_rdy = 1'b0;
        req(0);
        req(0);
        tick();
        chk("prerst_vld", 32'(gnt_vld), 1);
        axi_areset = 1'b1;
        tick();
        chk("midrst_vld", 32'(gnt_vld), 0);
        chk("midrst_err", 32'(err_oor), 0);
        chk("midrst_sts_rdy", 32'(tm_dsc_sts_rdy), 0);
        axi_areset = 1'b0;
        tick();
        for (int q = 0; q < 4; q++) chk_crd("postrst_credit", q, 0);
        gnt_rdy = 1'b1;
        sts(0, 100, 1'b0, 1'b0);
        repeat (5) tick();
        chk("postrst_no_gnt", 32'(gnt_vld), 0);
        chk_crd("postrst_credit0", 0, 100);
        chk("sb_empty", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
